fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_redirect_prio.sv | 25 ++
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: controller states, next-PC mux encodings
// and default address/line geometry.
package fetch_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int LINE_BYTES_DEF = 16;

    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } fetch_state_e;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] PC_SEL_EXC    = 2'd3;

endpackage

// File: rtl/fetch_redirect_prio.sv
// Redirect priority resolver: exception > jump > taken branch.
// Shared with the hazard unit so both agree on which redirect wins.
module fetch_redirect_prio
    import fetch_pkg::*;
(
    input  logic       exc,
    input  logic       jmp,
    input  logic       br,
    output logic       redir,
    output logic [1:0] sel
);

    always_comb begin
        redir = exc | jmp | br;
        sel   = PC_SEL_PLUS4;
        if (exc) begin
            sel = PC_SEL_EXC;
        end else if (jmp) begin
            sel = PC_SEL_JUMP;
        end else if (br) begin
            sel = PC_SEL_BRANCH;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller with single-outstanding line refill.
// Optional saturating performance counters are enabled by FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              imem_hit,
    input  logic              id_stall,
    input  logic              p2_isBranch,
    input  logic              p2_alu_flag_N,
    input  logic              isJump,
    input  logic              isException,
    input  logic              refill_ack,
    output logic              pcWrite,
    output logic [1:0]        pc_writeData_sel,
    output logic              p1_pipeline_regWrite,
    output logic              p1_flush,
    output logic              refill_req,
    output logic [ADDR_W-1:0] refill_addr,
`ifdef FETCH_CTRL_PERF_EN
    output logic [CNT_W-1:0]  perf_miss_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt,
`endif
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

    fetch_state_e      state_q, state_d;
    logic              refill_req_q, refill_req_d;
    logic [ADDR_W-1:0] refill_addr_q, refill_addr_d;
    logic              redir;
    logic [1:0]        redir_sel;

    fetch_redirect_prio u_prio (
        .exc   (isException),
        .jmp   (isJump),
        .br    (p2_isBranch & p2_alu_flag_N),
        .redir (redir),
        .sel   (redir_sel)
    );

    always_comb begin
        state_d              = state_q;
        refill_addr_d        = refill_addr_q;
        pcWrite              = 1'b0;
        pc_writeData_sel     = PC_SEL_PLUS4;
        p1_pipeline_regWrite = 1'b0;
        p1_flush             = 1'b0;
        if (redir) begin
            // A redirect never aborts an outstanding refill; it only rides along the ack.
            pcWrite              = 1'b1;
            pc_writeData_sel     = redir_sel;
            p1_pipeline_regWrite = 1'b1;
            p1_flush             = 1'b1;
            if (state_q == REFILL && refill_ack) begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (id_stall) begin
                pcWrite = 1'b0;
            end else if (imem_hit) begin
                pcWrite              = 1'b1;
                p1_pipeline_regWrite = 1'b1;
            end else begin
                p1_pipeline_regWrite = 1'b1;
                p1_flush             = 1'b1;
                state_d              = REFILL;
                refill_addr_d        = pc & LINE_MASK;
            end
        end else begin
            p1_pipeline_regWrite = ~id_stall;
            p1_flush             = 1'b1;
            if (refill_ack) begin
                state_d = RUN;
            end
        end
        refill_req_d = (state_d == REFILL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            refill_req_q  <= 1'b0;
            refill_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            refill_req_q  <= refill_req_d;
            refill_addr_q <= refill_addr_d;
        end
    end

    assign refill_req  = refill_req_q;
    assign refill_addr = refill_addr_q;
    assign busy        = (state_q != RUN);

`ifdef FETCH_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_miss_cnt_q, perf_miss_cnt_d;
    logic [CNT_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_miss_cnt_d  = perf_miss_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (state_q == RUN && state_d == REFILL && perf_miss_cnt_q != {CNT_W{1'b1}}) begin
            perf_miss_cnt_d = perf_miss_cnt_q + 1'b1;
        end
        if (state_q == REFILL && perf_stall_cnt_q != {CNT_W{1'b1}}) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_miss_cnt_q  <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_miss_cnt_q  <= perf_miss_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_miss_cnt  = perf_miss_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

`ifndef SYNTHESIS
    // An ack with no request outstanding means the memory side broke the handshake.
    a_no_stray_ack: assert property (@(posedge clk) disable iff (!reset)
        !(state_q == RUN && refill_ack));
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; perf counter checks are
// compiled in when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        imem_hit, id_stall, p2_isBranch, p2_alu_flag_N;
    logic        isJump, isException, refill_ack;
    logic        pcWrite, p1_pipeline_regWrite, p1_flush, refill_req, busy;
    logic [1:0]  pc_writeData_sel;
    logic [31:0] refill_addr;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_miss_cnt, perf_stall_cnt;
    logic        s_pcWrite, s_regWrite, s_flush, s_refill_req, s_busy;
    logic [1:0]  s_sel;
    logic [31:0] s_refill_addr;
    logic [3:0]  s_miss_cnt, s_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.ADDR_W(32), .LINE_BYTES(16), .CNT_W(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .pc                   (pc),
        .imem_hit             (imem_hit),
        .id_stall             (id_stall),
        .p2_isBranch          (p2_isBranch),
        .p2_alu_flag_N        (p2_alu_flag_N),
        .isJump               (isJump),
        .isException          (isException),
        .refill_ack           (refill_ack),
        .pcWrite              (pcWrite),
        .pc_writeData_sel     (pc_writeData_sel),
        .p1_pipeline_regWrite (p1_pipeline_regWrite),
        .p1_flush             (p1_flush),
        .refill_req           (refill_req),
        .refill_addr          (refill_addr),
`ifdef FETCH_CTRL_PERF_EN
        .perf_miss_cnt        (perf_miss_cnt),
        .perf_stall_cnt       (perf_stall_cnt),
`endif
        .busy                 (busy)
    );

`ifdef FETCH_CTRL_PERF_EN
    fetch_ctrl #(.ADDR_W(32), .LINE_BYTES(16), .CNT_W(4)) dut_small (
        .clk                  (clk),
        .reset                (reset),
        .pc                   (pc),
        .imem_hit             (imem_hit),
        .id_stall             (id_stall),
        .p2_isBranch          (p2_isBranch),
        .p2_alu_flag_N        (p2_alu_flag_N),
        .isJump               (isJump),
        .isException          (isException),
        .refill_ack           (refill_ack),
        .pcWrite              (s_pcWrite),
        .pc_writeData_sel     (s_sel),
        .p1_pipeline_regWrite (s_regWrite),
        .p1_flush             (s_flush),
        .refill_req           (s_refill_req),
        .refill_addr          (s_refill_addr),
        .perf_miss_cnt        (s_miss_cnt),
        .perf_stall_cnt       (s_stall_cnt),
        .busy                 (s_busy)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one clock; inputs change just after the edge, outputs settle by the next #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_hit      = 1'b1;
        id_stall      = 1'b0;
        p2_isBranch   = 1'b0;
        p2_alu_flag_N = 1'b0;
        isJump        = 1'b0;
        isException   = 1'b0;
        refill_ack    = 1'b0;
    endtask

    // Miss at addr, then n cycles in REFILL with the ack on the n-th.
    task automatic miss_refill(input logic [31:0] addr, input int n);
        pc       = addr;
        imem_hit = 1'b0;
        tick();
        imem_hit = 1'b1;
        for (int i = 0; i < n - 1; i++) tick();
        refill_ack = 1'b1;
        tick();
        refill_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pc    = 32'h0;
        idle_inputs();
        #2;
        check("rst_refill_req", {31'b0, refill_req}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_refill_addr", refill_addr, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("first_hit_pcWrite", {31'b0, pcWrite}, 32'd1);
        check("first_hit_sel", {30'b0, pc_writeData_sel}, 32'd0);
        check("first_hit_flush", {31'b0, p1_flush}, 32'd0);
        tick();

        // Miss at 0x104: bubbles while refilling line 0x100, ack on the 5th refill cycle.
        pc       = 32'h0000_0104;
        imem_hit = 1'b0;
        #1;
        check("miss_pcWrite", {31'b0, pcWrite}, 32'd0);
        check("miss_flush", {31'b0, p1_flush}, 32'd1);
        check("miss_regWrite", {31'b0, p1_pipeline_regWrite}, 32'd1);
        tick();
        imem_hit = 1'b0;
        #1;
        check("refill_req_set", {31'b0, refill_req}, 32'd1);
        check("refill_addr", refill_addr, 32'h0000_0100);
        check("refill_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("refill_bubble_pcWrite_%0d", i), {31'b0, pcWrite}, 32'd0);
            check($sformatf("refill_bubble_flush_%0d", i), {31'b0, p1_flush}, 32'd1);
            tick();
        end
        check("refill_addr_stable", refill_addr, 32'h0000_0100);
        refill_ack = 1'b1;
        #1;
        check("ack_cycle_pcWrite", {31'b0, pcWrite}, 32'd0);
        tick();
        refill_ack = 1'b0;
        imem_hit   = 1'b1;
        #1;
        check("after_ack_req", {31'b0, refill_req}, 32'd0);
        check("after_ack_busy", {31'b0, busy}, 32'd0);
        check("after_ack_pcWrite", {31'b0, pcWrite}, 32'd1);
        check("after_ack_sel", {30'b0, pc_writeData_sel}, 32'd0);

        // Redirect priority.
        isException = 1'b1; isJump = 1'b1; p2_isBranch = 1'b1; p2_alu_flag_N = 1'b1;
        #1;
        check("prio_all_sel", {30'b0, pc_writeData_sel}, 32'd3);
        check("prio_all_flush", {31'b0, p1_flush}, 32'd1);
        isException = 1'b0;
        #1;
        check("prio_jmp_br_sel", {30'b0, pc_writeData_sel}, 32'd2);
        isJump = 1'b0;
        #1;
        check("prio_br_sel", {30'b0, pc_writeData_sel}, 32'd1);
        check("prio_br_pcWrite", {31'b0, pcWrite}, 32'd1);
        p2_alu_flag_N = 1'b0;
        #1;
        check("br_not_taken_flush", {31'b0, p1_flush}, 32'd0);
        check("br_not_taken_sel", {30'b0, pc_writeData_sel}, 32'd0);
        p2_isBranch = 1'b0;

        // Stall holds; jump overrides stall; stall also masks a miss.
        id_stall = 1'b1;
        #1;
        check("stall_pcWrite", {31'b0, pcWrite}, 32'd0);
        check("stall_regWrite", {31'b0, p1_pipeline_regWrite}, 32'd0);
        isJump = 1'b1;
        #1;
        check("stall_jmp_pcWrite", {31'b0, pcWrite}, 32'd1);
        check("stall_jmp_sel", {30'b0, pc_writeData_sel}, 32'd2);
        check("stall_jmp_flush", {31'b0, p1_flush}, 32'd1);
        isJump   = 1'b0;
        imem_hit = 1'b0;
        tick();
        check("stall_miss_no_refill", {31'b0, busy}, 32'd0);
        id_stall = 1'b0;

        // Exception during refill does not abort it; redirect coincident with ack returns to RUN.
        pc       = 32'h0000_2238;
        imem_hit = 1'b0;
        tick();
        isException = 1'b1;
        #1;
        check("refill_exc_pcWrite", {31'b0, pcWrite}, 32'd1);
        check("refill_exc_sel", {30'b0, pc_writeData_sel}, 32'd3);
        tick();
        isException = 1'b0;
        pc          = 32'h0000_4000;
        #1;
        check("refill_exc_req_kept", {31'b0, refill_req}, 32'd1);
        check("refill_exc_addr_kept", refill_addr, 32'h0000_2230);
        id_stall = 1'b1;
        #1;
        check("refill_stall_regWrite", {31'b0, p1_pipeline_regWrite}, 32'd0);
        check("refill_stall_pcWrite", {31'b0, pcWrite}, 32'd0);
        id_stall   = 1'b0;
        isJump     = 1'b1;
        refill_ack = 1'b1;
        #1;
        check("redir_ack_sel", {30'b0, pc_writeData_sel}, 32'd2);
        tick();
        isJump     = 1'b0;
        refill_ack = 1'b0;
        imem_hit   = 1'b1;
        #1;
        check("redir_ack_busy", {31'b0, busy}, 32'd0);
        check("redir_ack_req", {31'b0, refill_req}, 32'd0);

        // Asynchronous reset mid-refill.
        pc       = 32'h0000_0300;
        imem_hit = 1'b0;
        tick();
        imem_hit = 1'b1;
        check("pre_reset_req", {31'b0, refill_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_req", {31'b0, refill_req}, 32'd0);
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset_pcWrite", {31'b0, pcWrite}, 32'd1);

`ifdef FETCH_CTRL_PERF_EN
        reset = 1'b0;
        #1;
        check("perf_rst_miss", perf_miss_cnt, 32'd0);
        check("perf_rst_stall", perf_stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        tick();
        miss_refill(32'h0000_1004, 4);
        miss_refill(32'h0000_2008, 4);
        miss_refill(32'h0000_300C, 4);
        check("perf_miss_3", perf_miss_cnt, 32'd3);
        check("perf_stall_12", perf_stall_cnt, 32'd12);
        check("perf_small_stall_12", {28'b0, s_stall_cnt}, 32'd12);
        miss_refill(32'h0000_4010, 8);
        check("perf_stall_20", perf_stall_cnt, 32'd20);
        check("perf_small_stall_sat", {28'b0, s_stall_cnt}, 32'd15);
        check("perf_small_miss_4", {28'b0, s_miss_cnt}, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
